// File: rtl/ap_arbiter.sv
// Two-requester round-robin arbiter for the shared ApLine command port.
// Each requester owns one pending slot; a grant walks ISSUE -> SETTLE -> WAIT -> DONE.
module ap_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic CoreApRequest,
    input  logic CoreDataRequest,
    input  logic CoreDec,
    input  logic PanelApRequest,
    input  logic PanelDataRequest,
    input  logic PanelDec,
    output logic ApRequest,
    output logic DataRequest,
    output logic Dec,
    input  logic ApLineReady,
    output logic CoreDone,
    output logic PanelDone,
    output logic Busy,
    output logic Timeout,
    input  logic ErrClr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COUNT_MAX   = '1;
    localparam logic OWNER_CORE  = 1'b0;
    localparam logic OWNER_PANEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        DONE
    } state_t;

    state_t state, state_next;
    logic owner, owner_next, last_owner;
    logic [CW-1:0] count, count_next, count_inc;
    logic timeout_set;

    logic core_pend, core_data, core_dec;
    logic panel_pend, panel_data, panel_dec;
    logic core_req, panel_req;
    logic sel_data, sel_dec;

    assign core_req  = CoreApRequest | CoreDataRequest;
    assign panel_req = PanelApRequest | PanelDataRequest;
    assign count_inc = (count == COUNT_MAX) ? count : count + CW'(1);
    assign sel_data  = (owner_next == OWNER_PANEL) ? panel_data : core_data;
    assign sel_dec   = (owner_next == OWNER_PANEL) ? panel_dec  : core_dec;

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        count_next  = count;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (core_pend || panel_pend) begin
                    state_next = ISSUE;
                    // On a tie, hand the line to whoever did not have it last
                    if (core_pend && panel_pend) begin
                        owner_next = ~last_owner;
                    end else begin
                        owner_next = panel_pend ? OWNER_PANEL : OWNER_CORE;
                    end
                end
            end
            ISSUE: begin
                count_next = '0;
                state_next = SETTLE;
            end
            SETTLE: begin
                count_next = count_inc;
                state_next = WAIT;
            end
            WAIT: begin
                count_next = count_inc;
                if (ApLineReady) begin
                    state_next = DONE;
                end else if (count == TIMEOUT_VAL) begin
                    timeout_set = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            owner      <= OWNER_CORE;
            last_owner <= OWNER_PANEL;
            count      <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            count <= count_next;
            if (state == DONE) begin
                last_owner <= owner;
            end
        end
    end

    // Slots clear when issued; a pulse into an already-pending slot is dropped
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            core_pend  <= 1'b0;
            core_data  <= 1'b0;
            core_dec   <= 1'b0;
            panel_pend <= 1'b0;
            panel_data <= 1'b0;
            panel_dec  <= 1'b0;
        end else begin
            if (state == ISSUE && owner == OWNER_CORE) begin
                core_pend <= 1'b0;
            end else if (core_req && !core_pend) begin
                core_pend <= 1'b1;
                core_data <= CoreDataRequest;
                core_dec  <= CoreDec;
            end
            if (state == ISSUE && owner == OWNER_PANEL) begin
                panel_pend <= 1'b0;
            end else if (panel_req && !panel_pend) begin
                panel_pend <= 1'b1;
                panel_data <= PanelDataRequest;
                panel_dec  <= PanelDec;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ApRequest   <= 1'b0;
            DataRequest <= 1'b0;
            Dec         <= 1'b0;
            CoreDone    <= 1'b0;
            PanelDone   <= 1'b0;
            Busy        <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            ApRequest   <= (state_next == ISSUE) && !sel_data;
            DataRequest <= (state_next == ISSUE) && sel_data;
            Dec         <= (state_next == ISSUE) && sel_dec;
            CoreDone    <= (state_next == DONE) && (owner_next == OWNER_CORE);
            PanelDone   <= (state_next == DONE) && (owner_next == OWNER_PANEL);
            Busy        <= (state_next != IDLE);
            if (timeout_set) begin
                Timeout <= 1'b1;
            end else if (ErrClr) begin
                Timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ap_arbiter.sv
// Self-checking bench for ap_arbiter: expected grants are queued as requests are
// driven and compared when the arbiter issues and completes them.
module tb_ap_arbiter;

    localparam int TO = 8;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic CoreApRequest = 1'b0, CoreDataRequest = 1'b0, CoreDec = 1'b0;
    logic PanelApRequest = 1'b0, PanelDataRequest = 1'b0, PanelDec = 1'b0;
    logic ApLineReady = 1'b0, ErrClr = 1'b0;
    logic ApRequest, DataRequest, Dec, CoreDone, PanelDone, Busy, Timeout;

    typedef struct {
        bit owner;
        bit data;
        bit dec;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    bit   model_last = 1'b1;

    ap_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .CoreApRequest(CoreApRequest), .CoreDataRequest(CoreDataRequest), .CoreDec(CoreDec),
        .PanelApRequest(PanelApRequest), .PanelDataRequest(PanelDataRequest), .PanelDec(PanelDec),
        .ApRequest(ApRequest), .DataRequest(DataRequest), .Dec(Dec),
        .ApLineReady(ApLineReady), .CoreDone(CoreDone), .PanelDone(PanelDone),
        .Busy(Busy), .Timeout(Timeout), .ErrClr(ErrClr)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) ncyc <= ncyc + 1;

    // One-cycle pulse, {ap, data, dec} per requester; called and returns on a negedge
    task automatic drive(input logic [2:0] c, input logic [2:0] p);
        {CoreApRequest, CoreDataRequest, CoreDec}    = c;
        {PanelApRequest, PanelDataRequest, PanelDec} = p;
        @(negedge Clk);
        {CoreApRequest, CoreDataRequest, CoreDec}    = 3'b000;
        {PanelApRequest, PanelDataRequest, PanelDec} = 3'b000;
    endtask

    task automatic wait_issue(input int limit, output bit seen, output int at,
                              output logic [2:0] cmd);
        seen = 1'b0;
        at   = -1;
        cmd  = 3'b000;
        for (int i = 0; i < limit; i++) begin
            @(negedge Clk);
            if (ApRequest || DataRequest) begin
                seen = 1'b1;
                at   = ncyc;
                cmd  = {ApRequest, DataRequest, Dec};
                break;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit seen, output int at,
                             output logic [1:0] dn);
        seen = 1'b0;
        at   = -1;
        dn   = 2'b00;
        for (int i = 0; i < limit; i++) begin
            @(negedge Clk);
            if (CoreDone || PanelDone) begin
                seen = 1'b1;
                at   = ncyc;
                dn   = {CoreDone, PanelDone};
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        outs = {ApRequest, DataRequest, Dec, CoreDone, PanelDone, Busy, Timeout};
        total++;
        if (outs !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b want 0000000", outs);
        end
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        outs = {ApRequest, DataRequest, Dec, CoreDone, PanelDone, Busy, Timeout};
        total++;
        if (outs !== 7'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle: got %b want 0000000", outs);
        end
    endtask

    task automatic test_ties(input int rounds);
        exp_t e;
        bit seen, first;
        int ti, td, tprev;
        logic [2:0] cmd;
        logic [1:0] dn;
        ApLineReady = 1'b1;
        for (int r = 0; r < rounds; r++) begin
            first = ~model_last;
            // Core carries dec=1 and Panel dec=0 so the issue order is visible
            if (first == 1'b0) begin
                exp_q.push_back('{owner: 1'b0, data: 1'b0, dec: 1'b1});
                exp_q.push_back('{owner: 1'b1, data: 1'b0, dec: 1'b0});
            end else begin
                exp_q.push_back('{owner: 1'b1, data: 1'b0, dec: 1'b0});
                exp_q.push_back('{owner: 1'b0, data: 1'b0, dec: 1'b1});
            end
            drive(3'b101, 3'b100);
            tprev = -1;
            for (int k = 0; k < 2; k++) begin
                wait_issue(20, seen, ti, cmd);
                e = exp_q.pop_front();
                total++;
                if (!seen || cmd !== {!e.data, e.data, e.dec}) begin
                    bad++;
                    $display("[TB] FAIL tie_issue r%0d k%0d: got seen=%0b cmd=%b want cmd=%b",
                             r, k, seen, cmd, {!e.data, e.data, e.dec});
                end
                if (k == 1) begin
                    total++;
                    if (ti - tprev !== 5) begin
                        bad++;
                        $display("[TB] FAIL tie_spacing r%0d: got %0d want 5", r, ti - tprev);
                    end
                end
                tprev = ti;
                wait_done(20, seen, td, dn);
                total++;
                if (!seen || dn !== {!e.owner, e.owner}) begin
                    bad++;
                    $display("[TB] FAIL tie_done r%0d k%0d: got seen=%0b done=%b want %b",
                             r, k, seen, dn, {!e.owner, e.owner});
                end
                model_last = e.owner;
            end
        end
    endtask

    task automatic test_single_data();
        exp_t e;
        bit seen;
        int ti, td;
        logic [2:0] cmd;
        logic [1:0] dn;
        ApLineReady = 1'b0;
        exp_q.push_back('{owner: 1'b0, data: 1'b1, dec: 1'b1});
        drive(3'b011, 3'b000);
        wait_issue(20, seen, ti, cmd);
        e = exp_q.pop_front();
        total++;
        if (!seen || cmd !== {!e.data, e.data, e.dec}) begin
            bad++;
            $display("[TB] FAIL single_issue: got seen=%0b cmd=%b want %b",
                     seen, cmd, {!e.data, e.data, e.dec});
        end
        @(negedge Clk);
        total++;
        if ({ApRequest, DataRequest, Dec} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL single_issue_width: got %b want 000",
                     {ApRequest, DataRequest, Dec});
        end
        repeat (4) @(negedge Clk);
        ApLineReady = 1'b1;
        wait_done(20, seen, td, dn);
        total++;
        if (!seen || dn !== {!e.owner, e.owner} || td - ti !== 6) begin
            bad++;
            $display("[TB] FAIL single_done: got seen=%0b done=%b lat=%0d want done=%b lat=6",
                     seen, dn, td - ti, {!e.owner, e.owner});
        end
        model_last = e.owner;
        @(negedge Clk);
        total++;
        if ({CoreDone, PanelDone} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL single_done_width: got %b want 00", {CoreDone, PanelDone});
        end
    endtask

    task automatic test_peer_during_wait();
        exp_t e;
        bit seen;
        int ti, td, ti2;
        logic [2:0] cmd;
        logic [1:0] dn;
        ApLineReady = 1'b0;
        exp_q.push_back('{owner: 1'b0, data: 1'b0, dec: 1'b1});
        drive(3'b101, 3'b000);
        wait_issue(20, seen, ti, cmd);
        e = exp_q.pop_front();
        total++;
        if (!seen || cmd !== {!e.data, e.data, e.dec}) begin
            bad++;
            $display("[TB] FAIL peer_core_issue: got seen=%0b cmd=%b want %b",
                     seen, cmd, {!e.data, e.data, e.dec});
        end
        repeat (2) @(negedge Clk);
        exp_q.push_back('{owner: 1'b1, data: 1'b1, dec: 1'b0});
        drive(3'b000, 3'b010);
        ApLineReady = 1'b1;
        wait_done(20, seen, td, dn);
        total++;
        if (!seen || dn !== {!e.owner, e.owner} || td - ti !== 4) begin
            bad++;
            $display("[TB] FAIL peer_core_done: got seen=%0b done=%b lat=%0d want done=%b lat=4",
                     seen, dn, td - ti, {!e.owner, e.owner});
        end
        model_last = e.owner;
        wait_issue(20, seen, ti2, cmd);
        e = exp_q.pop_front();
        total++;
        if (!seen || cmd !== {!e.data, e.data, e.dec} || ti2 - td !== 2) begin
            bad++;
            $display("[TB] FAIL peer_panel_issue: got seen=%0b cmd=%b gap=%0d want cmd=%b gap=2",
                     seen, cmd, ti2 - td, {!e.data, e.data, e.dec});
        end
        wait_done(20, seen, td, dn);
        total++;
        if (!seen || dn !== {!e.owner, e.owner}) begin
            bad++;
            $display("[TB] FAIL peer_panel_done: got seen=%0b done=%b want %b",
                     seen, dn, {!e.owner, e.owner});
        end
        model_last = e.owner;
    endtask

    task automatic test_double_pulse();
        exp_t e;
        bit seen;
        int td, extra;
        logic [1:0] dn;
        ApLineReady = 1'b1;
        exp_q.push_back('{owner: 1'b0, data: 1'b1, dec: 1'b1});
        {CoreApRequest, CoreDataRequest, CoreDec} = 3'b111;
        @(negedge Clk);
        {CoreApRequest, CoreDataRequest, CoreDec} = 3'b100;
        @(negedge Clk);
        {CoreApRequest, CoreDataRequest, CoreDec} = 3'b000;
        e = exp_q.pop_front();
        total++;
        if ({ApRequest, DataRequest, Dec} !== {!e.data, e.data, e.dec}) begin
            bad++;
            $display("[TB] FAIL double_issue: got %b want %b",
                     {ApRequest, DataRequest, Dec}, {!e.data, e.data, e.dec});
        end
        wait_done(20, seen, td, dn);
        total++;
        if (!seen || dn !== {!e.owner, e.owner}) begin
            bad++;
            $display("[TB] FAIL double_done: got seen=%0b done=%b want %b",
                     seen, dn, {!e.owner, e.owner});
        end
        model_last = e.owner;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (ApRequest || DataRequest || CoreDone || PanelDone) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("[TB] FAIL double_extra: got %0d extra events want 0", extra);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit seen;
        int ti, td;
        logic [2:0] cmd;
        logic [1:0] dn;
        ApLineReady = 1'b0;
        exp_q.push_back('{owner: 1'b0, data: 1'b0, dec: 1'b0});
        drive(3'b100, 3'b000);
        wait_issue(20, seen, ti, cmd);
        e = exp_q.pop_front();
        total++;
        if (!seen || cmd !== {!e.data, e.data, e.dec} || Timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL to_issue: got seen=%0b cmd=%b timeout=%b want cmd=%b timeout=0",
                     seen, cmd, Timeout, {!e.data, e.data, e.dec});
        end
        wait_done(40, seen, td, dn);
        total++;
        if (!seen || dn !== {!e.owner, e.owner} || td - ti !== TO + 2 || Timeout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_done: got seen=%0b done=%b lat=%0d timeout=%b want done=%b lat=%0d timeout=1",
                     seen, dn, td - ti, Timeout, {!e.owner, e.owner}, TO + 2);
        end
        model_last = e.owner;
        @(negedge Clk);
        total++;
        if (Busy !== 1'b0 || Timeout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_sticky: got busy=%b timeout=%b want busy=0 timeout=1",
                     Busy, Timeout);
        end
        ErrClr = 1'b1;
        @(negedge Clk);
        ErrClr = 1'b0;
        total++;
        if (Timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL to_errclr: got %b want 0", Timeout);
        end
        // ErrClr held through a second timeout: the set must still win
        ErrClr = 1'b1;
        exp_q.push_back('{owner: 1'b1, data: 1'b0, dec: 1'b1});
        drive(3'b000, 3'b101);
        wait_issue(20, seen, ti, cmd);
        e = exp_q.pop_front();
        wait_done(40, seen, td, dn);
        total++;
        if (!seen || dn !== {!e.owner, e.owner} || Timeout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_set_wins: got seen=%0b done=%b timeout=%b want done=%b timeout=1",
                     seen, dn, Timeout, {!e.owner, e.owner});
        end
        model_last = e.owner;
        @(negedge Clk);
        ErrClr = 1'b0;
        total++;
        if (Timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL to_clear_after: got %b want 0", Timeout);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit seen;
        int ti, act;
        logic [2:0] cmd;
        logic [6:0] outs;
        ApLineReady = 1'b0;
        exp_q.push_back('{owner: 1'b0, data: 1'b0, dec: 1'b1});
        drive(3'b101, 3'b000);
        wait_issue(20, seen, ti, cmd);
        e = exp_q.pop_front();
        total++;
        if (!seen || cmd !== {!e.data, e.data, e.dec}) begin
            bad++;
            $display("[TB] FAIL rmid_issue: got seen=%0b cmd=%b want %b",
                     seen, cmd, {!e.data, e.data, e.dec});
        end
        @(negedge Clk);
        drive(3'b000, 3'b100);
        @(negedge Clk);
        total++;
        if (Busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rmid_busy_before: got %b want 1", Busy);
        end
        Rst_n = 1'b0;
        #1;
        outs = {ApRequest, DataRequest, Dec, CoreDone, PanelDone, Busy, Timeout};
        total++;
        if (outs !== 7'b0) begin
            bad++;
            $display("[TB] FAIL rmid_async: got %b want 0000000", outs);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        ApLineReady = 1'b1;
        model_last = 1'b1;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (ApRequest || DataRequest || CoreDone || PanelDone || Busy) act++;
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("[TB] FAIL rmid_after: got %0d active cycles want 0", act);
        end
    endtask

    initial begin
        test_reset();
        test_ties(1);
        test_single_data();
        test_peer_during_wait();
        test_ties(2);
        test_double_pulse();
        test_timeout();
        test_reset_mid();
        test_ties(1);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/ap_arbiter.md
AP_ARBITER -- requirements
Module: ap_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum cycles to wait for ApLineReady before aborting a grant.
REQ-002 SHALL have port Clk, input, 1: single system clock; all state updates on posedge.
REQ-003 SHALL have port Rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports CoreApRequest / CoreDataRequest / CoreDec, input, 1 each: core requester; a request is a one-cycle pulse, and Dec is sampled in the same cycle.
REQ-005 SHALL have ports PanelApRequest / PanelDataRequest / PanelDec, input, 1 each: front-panel requester, with the same semantics as the core requester.
REQ-006 SHALL have ports ApRequest / DataRequest / Dec, output, 1 each: the command driven to the shared ApLine.
REQ-007 SHALL have port ApLineReady, input, 1: ApLine idle/complete level.
REQ-008 SHALL have ports CoreDone / PanelDone, output, 1 each: one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port Busy, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have ports Timeout, output, 1 (sticky error) and ErrClr, input, 1 (synchronous clear of Timeout).

Function
REQ-011 SHALL latch each requester's pulse into a pending slot {op, dec}, where op is AP or DATA; if both op bits are high in one pulse, DATA wins.
REQ-012 SHALL ignore a new pulse from a requester whose slot is already pending; the first request is kept.
REQ-013 SHALL use FSM states IDLE, ISSUE, SETTLE, WAIT, DONE.
REQ-014 In IDLE with any slot pending, the FSM SHALL select an owner and go to ISSUE next cycle. A pulse arriving in IDLE SHALL be granted no earlier than the following cycle.
REQ-015 Owner selection SHALL be round-robin:
- if both slots are pending, select the requester not granted last;
- if only one is pending, select it;
- the LastOwner reset value is Panel, so Core wins the first tie.
REQ-016 ISSUE SHALL:
- drive exactly one of ApRequest or DataRequest high for exactly one cycle, with Dec equal to the owner's latched dec;
- clear the owner's pending slot;
- go to SETTLE.
REQ-017 SETTLE SHALL last exactly one cycle, ignore ApLineReady, and go to WAIT.
REQ-018 WAIT SHALL go to DONE on the first cycle ApLineReady=1.
REQ-019 The timeout counter SHALL:
- load to 0 at ISSUE and increment each SETTLE/WAIT cycle;
- on reaching TIMEOUT_CYCLES in WAIT, set Timeout=1 and go to DONE;
- saturate, never wrap.
REQ-020 DONE SHALL pulse the owner's Done for one cycle, record LastOwner, and return to IDLE. If a slot is pending, the next ISSUE SHALL follow after the IDLE cycle (minimum issue-to-issue spacing = 5 cycles).
REQ-021 ApRequest, DataRequest, Dec, CoreDone and PanelDone SHALL be registered outputs, low in all states other than those specified above.
REQ-022 If ErrClr and a timeout event occur in the same cycle, Timeout SHALL be set (set wins).
REQ-023 The other requester's pulse SHALL be latched during any state, including while the FSM serves its peer.

Reset
REQ-024 With Rst_n=0, the block SHALL immediately (asynchronously) place the FSM in IDLE and clear:
- both pending slots and the counter;
- Timeout;
- all outputs (ApRequest, DataRequest, Dec, CoreDone, PanelDone, Busy) to 0.
REQ-025 A reset asserted mid-transaction SHALL abort it with no Done pulse; pending requests SHALL be lost.
REQ-026 After Rst_n deasserts, the first posedge SHALL evaluate IDLE; LastOwner SHALL be Panel.

Verification
REQ-027 Single core DATA+dec request, ApLineReady low for 3 cycles after SETTLE -> DataRequest=1 and Dec=1 for one cycle; CoreDone pulses 6 cycles after ISSUE; PanelDone stays 0.
REQ-028 Core and Panel pulse in the same cycle (AP ops) -> Core is issued first and Panel second; issue-to-issue spacing is 5 cycles with Ready held high.
REQ-029 Panel pulses during a Core WAIT -> Panel is served immediately after CoreDone with no loss; repeated ties alternate owners.
REQ-030 With TIMEOUT_CYCLES=8 and ApLineReady stuck at 0 -> Timeout=1 after 8 counted cycles, owner Done pulses, and the FSM returns to IDLE; ErrClr then clears Timeout.
REQ-031 Rst_n pulled low in WAIT -> all outputs are 0 immediately; after release, no Done pulse occurs and Busy=0.
REQ-032 Core pulses twice while pending, and one pulse has both Ap and Data high -> exactly one DATA issue and one CoreDone.
